// File: rtl/flag_cond_unit.sv
// ALU flag register {Z,N,C,V} with masked writes, plus a one-deep condition-code evaluation stage.
// Optional FLAG_SHADOW_EN adds a one-deep shadow copy of the flags with save/restore controls.
//
// state | meaning
// IDLE  | no result held, res_valid=0
// FULL  | result held in res_taken, res_valid=1
module flag_cond_unit #(
    parameter int unsigned COND_W    = 4,
    parameter logic [3:0]  FLAGS_RST = 4'b0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flag_we,
    input  logic [3:0]        flag_mask,
    input  logic              z_in,
    input  logic              n_in,
    input  logic              c_in,
    input  logic              v_in,
`ifdef FLAG_SHADOW_EN
    input  logic              flag_save,
    input  logic              flag_restore,
`endif
    input  logic              cond_valid,
    output logic              cond_ready,
    input  logic [COND_W-1:0] cond,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_taken,
    output logic [3:0]        flags
);

    typedef enum logic {IDLE, FULL} state_t;

    state_t     state_q;
    logic       res_valid_q;
    logic       res_taken_q;
    logic [3:0] flags_q;
    logic [3:0] flags_d;
    logic       accept;
    logic       taken_d;

    function automatic logic cond_eval(input logic [COND_W-1:0] cc, input logic [3:0] f);
        logic z, n, c, v;
        logic r;
        z = f[3];
        n = f[2];
        c = f[1];
        v = f[0];
        case (cc)
            4'd0:    r = z;
            4'd1:    r = !z;
            4'd2:    r = c;
            4'd3:    r = !c;
            4'd4:    r = n;
            4'd5:    r = !n;
            4'd6:    r = v;
            4'd7:    r = !v;
            4'd8:    r = c & !z;
            4'd9:    r = !c | z;
            4'd10:   r = (n == v);
            4'd11:   r = (n != v);
            4'd12:   r = !z & (n == v);
            4'd13:   r = z | (n != v);
            4'd14:   r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

`ifdef FLAG_SHADOW_EN
    logic [3:0] shadow_q;
    logic [3:0] shadow_d;
`endif

    // flags_d is the post-edge flag value, so it doubles as the forwarded flags for evaluation.
    always_comb begin
        flags_d = flags_q;
        if (flag_we)
            flags_d = (flags_q & ~flag_mask) | ({z_in, n_in, c_in, v_in} & flag_mask);
`ifdef FLAG_SHADOW_EN
        shadow_d = shadow_q;
        if (flag_save)
            shadow_d = flags_q;
        if (flag_restore)
            flags_d = shadow_q;
`endif
    end

    assign cond_ready = !res_valid_q || res_ready;
    assign accept     = cond_valid && cond_ready;
    assign taken_d    = cond_eval(cond, flags_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= FLAGS_RST;
        end else begin
            flags_q <= flags_d;
        end
    end

`ifdef FLAG_SHADOW_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= FLAGS_RST;
        end else begin
            shadow_q <= shadow_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
            res_taken_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= FULL;
                        res_valid_q <= 1'b1;
                        res_taken_q <= taken_d;
                    end
                end
                FULL: begin
                    if (res_ready) begin
                        if (accept) begin
                            res_taken_q <= taken_d;
                        end else begin
                            state_q     <= IDLE;
                            res_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    res_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_taken = res_taken_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_flag_cond_unit.sv
// Bench for flag_cond_unit: directed scenarios pinned with literals, then randomized traffic vs a model.
module tb_flag_cond_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flag_we;
    logic [3:0] flag_mask;
    logic       z_in, n_in, c_in, v_in;
    logic       cond_valid;
    logic       cond_ready;
    logic [3:0] cond;
    logic       res_valid;
    logic       res_ready;
    logic       res_taken;
    logic [3:0] flags;
`ifdef FLAG_SHADOW_EN
    logic       flag_save;
    logic       flag_restore;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // model state
    bit       m_valid;
    bit       m_taken;
    bit [3:0] m_flags;
    bit [3:0] m_shadow;

    always #5 clk = ~clk;

    flag_cond_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flag_we    (flag_we),
        .flag_mask  (flag_mask),
        .z_in       (z_in),
        .n_in       (n_in),
        .c_in       (c_in),
        .v_in       (v_in),
`ifdef FLAG_SHADOW_EN
        .flag_save  (flag_save),
        .flag_restore(flag_restore),
`endif
        .cond_valid (cond_valid),
        .cond_ready (cond_ready),
        .cond       (cond),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_taken  (res_taken),
        .flags      (flags)
    );

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Conditions come in complementary pairs: even code = base test, odd code = its negation.
    function automatic bit model_eval(input int cc, input bit [3:0] f);
        bit z, n, c, v, base;
        z = f[3]; n = f[2]; c = f[1]; v = f[0];
        case (cc / 2)
            0: base = z;
            1: base = c;
            2: base = n;
            3: base = v;
            4: base = c && !z;
            5: base = (n == v);
            6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return base ^ cc[0];
    endfunction

    task automatic model_reset();
        m_valid  = 0;
        m_taken  = 0;
        m_flags  = 4'b0000;
        m_shadow = 4'b0000;
    endtask

    // Called after inputs are driven (just past negedge); compares, advances the model, waits for next negedge.
    task automatic step();
        bit [3:0] nf;
        bit [3:0] in_v;
        bit       acc;
        if (!rst_n) model_reset();
        #1;
        chk("flags",      flags,      {1'b0, 1'b0, 1'b0, 1'b0} | m_flags);
        chk("res_valid",  {3'b0, res_valid},  {3'b0, m_valid});
        if (m_valid) chk("res_taken", {3'b0, res_taken}, {3'b0, m_taken});
        chk("cond_ready", {3'b0, cond_ready}, {3'b0, (!m_valid || res_ready)});
        if (rst_n) begin
            in_v = {z_in, n_in, c_in, v_in};
            nf = m_flags;
            for (int i = 0; i < 4; i++)
                if (flag_we && flag_mask[i]) nf[i] = in_v[i];
`ifdef FLAG_SHADOW_EN
            if (flag_restore) nf = m_shadow;
            if (flag_save) m_shadow = m_flags;
`endif
            acc = cond_valid && (!m_valid || res_ready);
            if (acc) begin
                m_valid = 1;
                m_taken = model_eval(int'(cond), nf);
            end else if (res_ready) begin
                m_valid = 0;
            end
            m_flags = nf;
        end
        @(negedge clk);
    endtask

    task automatic drive(input bit we, input bit [3:0] mask, input bit [3:0] zncv,
                         input bit cv, input int cc, input bit rr);
        flag_we = we; flag_mask = mask;
        {z_in, n_in, c_in, v_in} = zncv;
        cond_valid = cv; cond = 4'(cc); res_ready = rr;
`ifdef FLAG_SHADOW_EN
        flag_save = 0; flag_restore = 0;
`endif
    endtask

    initial begin
        rst_n = 0;
        drive(0, 4'h0, 4'h0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        step();
        chk("post_reset_ready", {3'b0, cond_ready}, 4'd1);
        chk("post_reset_flags", flags, 4'b0000);

        // Forwarding: write Z=1 and evaluate EQ in the same cycle.
        drive(1, 4'hF, 4'b1000, 1, 0, 1);
        step();
        chk("fwd_eq_valid", {3'b0, res_valid}, 4'd1);
        chk("fwd_eq_taken", {3'b0, res_taken}, 4'd1);
        drive(0, 4'h0, 4'h0, 1, 1, 1);
        step();
        chk("fwd_ne_taken", {3'b0, res_taken}, 4'd0);

        // Masked write: 1111 then update only Z,N to 0 -> 0011 (C=1,V=1).
        drive(1, 4'hF, 4'b1111, 0, 0, 1);
        step();
        drive(1, 4'b1100, 4'b0000, 1, 8, 1);
        step();
        chk("mask_flags", flags, 4'b0011);
        chk("mask_hi", {3'b0, res_taken}, 4'd1);
        drive(0, 4'h0, 4'h0, 1, 11, 1);
        step();
        chk("mask_lt", {3'b0, res_taken}, 4'd1);
        drive(0, 4'h0, 4'h0, 1, 10, 1);
        step();
        chk("mask_ge", {3'b0, res_taken}, 4'd0);

        // Signed/unsigned: Z=0 N=1 C=0 V=1.
        drive(1, 4'hF, 4'b0101, 1, 10, 1);
        step();
        chk("sgn_ge", {3'b0, res_taken}, 4'd1);
        drive(0, 4'h0, 4'h0, 1, 12, 1); step(); chk("sgn_gt", {3'b0, res_taken}, 4'd1);
        drive(0, 4'h0, 4'h0, 1, 11, 1); step(); chk("sgn_lt", {3'b0, res_taken}, 4'd0);
        drive(0, 4'h0, 4'h0, 1, 2, 1);  step(); chk("sgn_cs", {3'b0, res_taken}, 4'd0);
        drive(0, 4'h0, 4'h0, 1, 9, 1);  step(); chk("sgn_ls", {3'b0, res_taken}, 4'd1);
        drive(0, 4'h0, 4'h0, 1, 14, 1); step(); chk("sgn_al", {3'b0, res_taken}, 4'd1);
        drive(0, 4'h0, 4'h0, 1, 15, 1); step(); chk("sgn_nv", {3'b0, res_taken}, 4'd0);

        // Backpressure: hold an EQ=1 result while Z is cleared underneath it.
        drive(1, 4'hF, 4'b1000, 1, 0, 1);
        step();
        chk("bp_first", {3'b0, res_taken}, 4'd1);
        for (int k = 0; k < 3; k++) begin
            drive(1, 4'b1000, 4'b0000, 1, 1, 0);
            #1 chk("bp_ready_low", {3'b0, cond_ready}, 4'd0);
            step();
            chk("bp_hold_valid", {3'b0, res_valid}, 4'd1);
            chk("bp_hold_taken", {3'b0, res_taken}, 4'd1);
        end
        drive(0, 4'h0, 4'h0, 1, 0, 1);
        step();
        chk("bp_b2b_valid", {3'b0, res_valid}, 4'd1);
        chk("bp_b2b_taken", {3'b0, res_taken}, 4'd0);

        // Asynchronous reset while FULL.
        drive(1, 4'hF, 4'b1111, 0, 0, 0);
        #2 rst_n = 0;
        model_reset();
        #1;
        chk("rst_valid", {3'b0, res_valid}, 4'd0);
        chk("rst_flags", flags, 4'b0000);
        step();
        rst_n = 1;
        drive(0, 4'h0, 4'h0, 0, 0, 0);
        step();
        chk("rst_release_ready", {3'b0, cond_ready}, 4'd1);

`ifdef FLAG_SHADOW_EN
        drive(1, 4'hF, 4'b1010, 0, 0, 1);
        step();
        drive(0, 4'h0, 4'h0, 0, 0, 1);
        flag_save = 1;
        step();
        drive(1, 4'hF, 4'b0101, 0, 0, 1);
        step();
        drive(0, 4'h0, 4'h0, 1, 0, 1);
        flag_restore = 1;
        step();
        chk("shadow_eq", {3'b0, res_taken}, 4'd1);
        chk("shadow_flags", flags, 4'b1010);
`endif

        // Randomized traffic, including occasional mid-cycle resets.
        for (int t = 0; t < 3000; t++) begin
            drive($urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 3) != 0);
`ifdef FLAG_SHADOW_EN
            flag_save    = $urandom_range(0, 7) == 0;
            flag_restore = $urandom_range(0, 7) == 0;
`endif
            rst_n = ($urandom_range(0, 299) != 0);
            step();
        end
        rst_n = 1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
